// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
// Central stall/flush sequencer for the 5-stage MIPS pipeline. Merges
// load-use hazards, taken-branch flushes, data-memory waits and
// fixed-latency mult/div occupancy of EX into one set of per-stage
// register enables and bubble-insert flushes. It also keeps a saturating
// count of cycles in which the PC was frozen.
//
// Handshake note: mem_req/mem_ready is a plain request/complete pair. A
// data-memory access in MEM is outstanding while mem_req=1 and mem_ready=0.
// The whole pipeline freezes for that time. The access retires on the
// cycle where mem_req=1 and mem_ready=1. mem_ready is ignored while
// mem_req=0.
//
// Enables and flushes are Mealy outputs: they depend on the registered
// state and on the current inputs. A stall therefore takes effect in the
// same cycle in which it is detected.
module pipeline_stall_ctrl #(
  parameter int MDU_LAT = 4,   // cycles a mult/div occupies EX (2..15)
  parameter int CNT_W   = 4,   // must hold MDU_LAT-1
  parameter int PERF_W  = 16   // stall-cycle counter width
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rt,
  input  logic [4:0]        ex_rt,
  input  logic              ex_memread,
  input  logic              ex_branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  input  logic              id_mdu_start,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              exmem_en,
  output logic              memwb_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic [1:0]        ctrl_state,
  output logic [PERF_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MDU_WAIT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MDU_LOAD = CNT_W'(MDU_LAT - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              memstall;
  logic              loaduse;
  logic              rs_match;
  logic              rt_match;

  // Hazard conditions seen this cycle. $0 is hard-wired zero and never
  // carries a dependency.
  always_comb begin
    memstall = mem_req & ~mem_ready;
    rs_match = (ex_rt == id_rs);
    rt_match = id_uses_rt & (ex_rt == id_rt);
    loaduse  = ex_memread & (ex_rt != 5'd0) & (rs_match | rt_match);
  end

  // Next-state and Mealy enable/flush decode.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;

    if (rst) begin
      // Outputs stay at defaults while reset is held. The register
      // block applies the actual reset values.
      state_nxt = RUN;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        // RUN and MEM_WAIT share the same decode. MEM_WAIT differs
        // only in that the pipeline is already frozen when entered.
        // Branch and load-use inputs held during the wait are
        // evaluated on the release cycle.
        RUN, MEM_WAIT: begin
          if (memstall) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_en  = 1'b0;
            memwb_en  = 1'b0;
            state_nxt = MEM_WAIT;
          end else if (ex_branch_taken) begin
            // Squash the wrong-path instructions in IF and ID. This
            // also drops any hazard or MDU start raised from ID.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_nxt  = RUN;
          end else if (loaduse) begin
            // Hold IF/ID for one cycle and send a bubble into EX.
            // The load leaves EX, so the hazard clears next cycle.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            state_nxt  = RUN;
          end else if (id_mdu_start) begin
            // The mult/div instruction enters EX this edge and stays
            // there for MDU_LAT cycles in total.
            cnt_nxt   = MDU_LOAD;
            state_nxt = MDU_WAIT;
          end else begin
            state_nxt = RUN;
          end
        end

        // The mult/div instruction occupies EX. Younger instructions
        // are held, and bubbles drain into MEM behind it.
        MDU_WAIT: begin
          if (memstall) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
          end else if (cnt != '0) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_flush = 1'b1;
            cnt_nxt     = cnt - 1'b1;
          end else begin
            state_nxt = RUN;
          end
        end

        default: begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // FSM state and MDU occupancy counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Saturating count of cycles with the PC frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (!pc_en && !(&stall_count)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

  // Expose the registered state for debug and checker binding.
  always_comb begin
    ctrl_state = state;
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl
// Randomised and directed stimulus for pipeline_stall_ctrl. Each cycle
// is compared against a behavioural model. The model tracks "memory wait
// pending" and "EX occupancy cycles remaining" for the mult/div
// instruction.
module tb_pipeline_stall_ctrl;

  localparam int MDU_LAT = 4;
  localparam int CNT_W   = 4;
  localparam int PERF_W  = 4;
  localparam int SAT     = (1 << PERF_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, ex_memread, ex_branch_taken;
  logic        mem_req, mem_ready, id_mdu_start;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush;
  logic [1:0]  ctrl_state;
  logic [PERF_W-1:0] stall_count;

  pipeline_stall_ctrl #(
    .MDU_LAT(MDU_LAT), .CNT_W(CNT_W), .PERF_W(PERF_W)
  ) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rt(ex_rt), .ex_memread(ex_memread),
    .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .id_mdu_start(id_mdu_start),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush),
    .ctrl_state(ctrl_state), .stall_count(stall_count)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [12:0] exp_q[$];  // {state[1:0], flush[2:0], en[4:0], pad[2:0]}

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_mem_wait;     // memory wait pending
  int m_mdu_left;     // EX occupancy cycles left for the mult/div (0 = none)
  int m_stalls;       // expected stall_count

  // Model one cycle: check DUT outputs against the rules, then advance
  // the model at the clock edge.
  task automatic step();
    logic [4:0] en;
    logic [2:0] fl;
    logic [1:0] st;
    logic [12:0] exp_v;
    bit memstall, loaduse, n_mem;
    int n_left;
    #1;
    memstall = mem_req && !mem_ready;
    loaduse  = ex_memread && ex_rt != 0 &&
               (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    en = 5'b11111; fl = 3'b000;
    n_mem = m_mem_wait; n_left = m_mdu_left;
    st = (m_mdu_left > 0) ? 2'd2 : (m_mem_wait ? 2'd1 : 2'd0);
    if (rst) begin
      n_mem = 0; n_left = 0;
    end else if (m_mdu_left > 0) begin
      if (memstall) en = 5'b00000;
      else if (m_mdu_left > 1) begin
        en = 5'b00011; fl = 3'b001; n_left = m_mdu_left - 1;
      end else n_left = 0;
    end else if (memstall) begin
      en = 5'b00000; n_mem = 1;
    end else begin
      n_mem = 0;
      if (ex_branch_taken) fl = 3'b110;
      else if (loaduse) begin en = 5'b00111; fl = 3'b010; end
      else if (id_mdu_start) n_left = MDU_LAT;
    end
    exp_q.push_back({st, fl, en, 3'b000});
    exp_v = exp_q.pop_front();
    check_val("enables", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, exp_v[7:3]);
    check_val("flushes", {ifid_flush, idex_flush, exmem_flush}, exp_v[10:8]);
    check_val("ctrl_state", ctrl_state, exp_v[12:11]);
    check_val("stall_count", stall_count, m_stalls);
    @(posedge clk);
    m_mem_wait = n_mem;
    m_mdu_left = n_left;
    if (rst) m_stalls = 0;
    else if (!en[4] && m_stalls < SAT) m_stalls++;
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    rst = 0; id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 0;
    ex_rt = 5'd3; ex_memread = 0; ex_branch_taken = 0;
    mem_req = 0; mem_ready = 0; id_mdu_start = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; mem_req = 1; mem_ready = 0;
    step(); step();
    idle_inputs();
  endtask

  task automatic drive_random();
    rst             = ($urandom_range(99) < 2);
    id_rs           = 5'($urandom_range(3));
    id_rt           = 5'($urandom_range(3));
    ex_rt           = 5'($urandom_range(3));
    id_uses_rt      = 1'($urandom_range(1));
    ex_memread      = ($urandom_range(99) < 40);
    ex_branch_taken = ($urandom_range(99) < 15);
    mem_req         = ($urandom_range(99) < 30);
    mem_ready       = 1'($urandom_range(1));
    id_mdu_start    = ($urandom_range(99) < 15);
  endtask

  int mdu_cycles;

  initial begin
    idle_inputs();
    m_mem_wait = 0; m_mdu_left = 0; m_stalls = 0;
    @(negedge clk);

    // Reset with a pending memory stall on the inputs.
    do_reset();
    #1;
    check_val("post_reset_state", ctrl_state, 0);
    check_val("post_reset_count", stall_count, 0);
    check_val("post_reset_pc_en", pc_en, 1);

    // Load-use on rs gives one bubble. ex_rt = 0 gives none.
    ex_memread = 1; ex_rt = 5'd8; id_rs = 5'd8; step();
    idle_inputs(); step();
    check_val("loaduse_count", stall_count, 1);
    ex_memread = 1; ex_rt = 5'd0; id_rs = 5'd0; step();
    idle_inputs(); step();
    check_val("r0_no_stall", stall_count, 1);

    // A taken branch takes priority over a load-use hazard.
    ex_memread = 1; ex_rt = 5'd8; id_rs = 5'd8; ex_branch_taken = 1; step();
    idle_inputs(); step();
    check_val("branch_no_stall", stall_count, 1);

    // Memory wait: 3 stalled cycles, then release.
    do_reset();
    mem_req = 1; mem_ready = 0;
    repeat (3) step();
    mem_ready = 1; step();
    idle_inputs(); step();
    check_val("memwait_count", stall_count, 3);

    // MDU with a 2-cycle memstall in the middle of the wait.
    do_reset();
    mdu_cycles = 0;
    id_mdu_start = 1; step(); idle_inputs();
    for (int i = 0; i < 12; i++) begin
      if (i == 1 || i == 2) begin mem_req = 1; mem_ready = 0; end
      else idle_inputs();
      #1;
      if (ctrl_state == 2'd2) mdu_cycles++;
      step();
    end
    check_val("mdu_occupancy", mdu_cycles, MDU_LAT + 2);
    check_val("mdu_count", stall_count, MDU_LAT - 1 + 2);

    // Saturation: a 20-cycle memstall stops the counter at all-ones.
    do_reset();
    mem_req = 1; mem_ready = 0;
    repeat (20) step();
    idle_inputs(); step();
    check_val("saturation", stall_count, SAT);

    // Random traffic, including mid-operation resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
